// File: rtl/uart_tx_resp_scheduler.sv
// Queues RegFile/ALU response words and streams them LSB-first into UART_TX, paced by tx_busy.
// Optional FRAME_HDR_EN: each word is prefixed by a tag byte (5A for RF, A5 for ALU).
module uart_tx_resp_scheduler #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          rf_vld,
  input  logic [DATA_WIDTH-1:0]         rf_data,
  input  logic                          alu_vld,
  input  logic [2*DATA_WIDTH-1:0]       alu_data,
  input  logic                          tx_busy,
  output logic [7:0]                    tx_p_data,
  output logic                          tx_d_vld,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full,
  output logic                          drop_err,
  output logic                          sched_busy
);

  localparam int unsigned PAY_W = 2 * DATA_WIDTH;
  localparam int unsigned ENT_W = PAY_W + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
`ifdef FRAME_HDR_EN
  localparam int unsigned HDR_BYTES = 1;
`else
  localparam int unsigned HDR_BYTES = 0;
`endif
  localparam int unsigned SHIFT_W   = PAY_W + 8 * HDR_BYTES;
  localparam int unsigned RF_BYTES  = DATA_WIDTH / 8 + HDR_BYTES;
  localparam int unsigned ALU_BYTES = PAY_W / 8 + HDR_BYTES;
  localparam int unsigned BCNT_W    = $clog2(ALU_BYTES + 1);
  localparam int unsigned TMR_W     = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  state_e              state_q;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                full_q, drop_q, busy_q, tx_vld_q;
  logic [7:0]          tx_data_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic [BCNT_W-1:0]   byte_cnt_q;
  logic [TMR_W-1:0]    timer_q;

  logic                pop, push_rf, push_alu, drop;
  logic [CNT_W-1:0]    free_slots, n_push, count_d;
  logic [PTR_W-1:0]    wr_ptr_nx, alu_slot;
  logic [ENT_W-1:0]    head;
  logic                head_is_alu;
  logic [PAY_W-1:0]    head_payload;
  logic [SHIFT_W-1:0]  load_shift;

  assign head         = mem_q[rd_ptr_q];
  assign head_is_alu  = head[PAY_W];
  assign head_payload = head[PAY_W-1:0];

`ifdef FRAME_HDR_EN
  assign load_shift = {head_payload, (head_is_alu ? 8'hA5 : 8'h5A)};
`else
  assign load_shift = head_payload;
`endif

  // Space check counts the slot freed by a same-cycle pop; RF wins when only one slot is left.
  always_comb begin
    pop        = (state_q == ST_LOAD) && !tx_busy && (count_q != '0);
    free_slots = CNT_W'(FIFO_DEPTH) - count_q + CNT_W'(pop);
    push_rf    = 1'b0;
    push_alu   = 1'b0;
    drop       = 1'b0;
    if (rf_vld && alu_vld) begin
      push_rf  = (free_slots >= CNT_W'(1));
      push_alu = (free_slots >= CNT_W'(2));
      drop     = (free_slots <  CNT_W'(2));
    end else if (rf_vld) begin
      push_rf  = (free_slots >= CNT_W'(1));
      drop     = (free_slots == '0);
    end else if (alu_vld) begin
      push_alu = (free_slots >= CNT_W'(1));
      drop     = (free_slots == '0);
    end
    n_push    = CNT_W'(push_rf) + CNT_W'(push_alu);
    count_d   = count_q + n_push - CNT_W'(pop);
    wr_ptr_nx = wr_ptr_q + PTR_W'(1);
    alu_slot  = push_rf ? wr_ptr_nx : wr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (push_rf)  mem_q[wr_ptr_q] <= {1'b0, PAY_W'(rf_data)};
    if (push_alu) mem_q[alu_slot] <= {1'b1, alu_data};
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(FIFO_DEPTH));
      drop_q   <= drop;
    end
  end

  // Strobe and byte are registered on entry to SEND, so tx_d_vld is high exactly while in SEND.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      timer_q    <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_vld_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (count_q != '0) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (pop) begin
            shift_q    <= load_shift;
            byte_cnt_q <= head_is_alu ? BCNT_W'(ALU_BYTES) : BCNT_W'(RF_BYTES);
            tx_data_q  <= load_shift[7:0];
            tx_vld_q   <= 1'b1;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          timer_q <= '0;
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (timer_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
            tx_vld_q <= 1'b1;
            state_q  <= ST_SEND;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (byte_cnt_q > BCNT_W'(1)) begin
              byte_cnt_q <= byte_cnt_q - BCNT_W'(1);
              shift_q    <= shift_q >> 8;
              tx_data_q  <= shift_q[15:8];
              tx_vld_q   <= 1'b1;
              state_q    <= ST_SEND;
            end else begin
              byte_cnt_q <= '0;
              if (count_q != '0) begin
                state_q <= ST_LOAD;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_p_data  = tx_data_q;
  assign tx_d_vld   = tx_vld_q;
  assign fifo_level = count_q;
  assign fifo_full  = full_q;
  assign drop_err   = drop_q;
  assign sched_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_resp_scheduler.sv
// Bench for uart_tx_resp_scheduler: queue/byte-list reference model compared every cycle,
// directed literal checks, then randomized traffic against a reactive UART busy model.
`timescale 1ns/1ps
module tb_uart_tx_resp_scheduler;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          is_alu;
    logic [63:0] pay;
  } ent_t;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        rf_vld = 1'b0;
  logic [31:0] rf_data = '0;
  logic        alu_vld = 1'b0;
  logic [63:0] alu_data = '0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_p_data;
  logic        tx_d_vld;
  logic [2:0]  fifo_level;
  logic        fifo_full;
  logic        drop_err;
  logic        sched_busy;

  uart_tx_resp_scheduler #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .RST(RST), .rf_vld(rf_vld), .rf_data(rf_data), .alu_vld(alu_vld),
    .alu_data(alu_data), .tx_busy(tx_busy), .tx_p_data(tx_p_data), .tx_d_vld(tx_d_vld),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .drop_err(drop_err), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int bmode = 1;          // 0: 10-cycle frames, 1: never busy, 2: stuck busy, 3: random
  logic [7:0] slog[$];
  int         clog[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bq_t word_bytes(input ent_t e);
    bq_t b;
    int  n;
`ifdef FRAME_HDR_EN
    b.push_back(e.is_alu ? 8'hA5 : 8'h5A);
`endif
    n = e.is_alu ? 8 : 4;
    for (int k = 0; k < n; k++) b.push_back(8'(e.pay >> (8 * k)));
    return b;
  endfunction

  // Reference model: queue of words, list of bytes left in the current word, line-wait counter.
  ent_t       mq[$];
  logic [7:0] mbytes[$];
  int         m_ph = 0;   // 0 idle, 1 wait line free, 2 strobing, 3 await busy rise, 4 await busy fall
  int         m_wait = 0;
  bit         m_vld = 0, m_drop = 0, m_sbusy = 0, m_full = 0;
  logic [7:0] m_byte = '0;
  int         m_level = 0;

  always @(posedge clk) begin : model
    int   pre;
    int   fr;
    ent_t e;
    cyc++;
    m_drop = 1'b0;
    if (RST) begin
      mq.delete();
      mbytes.delete();
      m_ph = 0; m_wait = 0; m_vld = 1'b0; m_byte = '0; m_sbusy = 1'b0;
    end else begin
      pre   = mq.size();
      m_vld = 1'b0;
      case (m_ph)
        0: if (pre != 0) begin m_ph = 1; m_sbusy = 1'b1; end
        1: if (!tx_busy) begin
             e = mq.pop_front();
             mbytes = word_bytes(e);
             m_byte = mbytes.pop_front();
             m_vld = 1'b1; m_ph = 2;
           end
        2: begin m_wait = 0; m_ph = 3; end
        3: if (tx_busy) m_ph = 4;
           else begin
             m_wait++;
             if (m_wait == TMO) begin m_vld = 1'b1; m_ph = 2; end
           end
        4: if (!tx_busy) begin
             if (mbytes.size() > 0) begin
               m_byte = mbytes.pop_front(); m_vld = 1'b1; m_ph = 2;
             end else if (pre != 0) m_ph = 1;
             else begin m_ph = 0; m_sbusy = 1'b0; end
           end
        default: m_ph = 0;
      endcase
      fr = DEPTH - mq.size();
      if (rf_vld && alu_vld) begin
        if (fr >= 1) begin e.is_alu = 1'b0; e.pay = 64'(rf_data); mq.push_back(e); end
        if (fr >= 2) begin e.is_alu = 1'b1; e.pay = alu_data; mq.push_back(e); end
        if (fr < 2) m_drop = 1'b1;
      end else if (rf_vld) begin
        if (fr >= 1) begin e.is_alu = 1'b0; e.pay = 64'(rf_data); mq.push_back(e); end
        else m_drop = 1'b1;
      end else if (alu_vld) begin
        if (fr >= 1) begin e.is_alu = 1'b1; e.pay = alu_data; mq.push_back(e); end
        else m_drop = 1'b1;
      end
    end
    m_level = mq.size();
    m_full  = (m_level == DEPTH);
  end

  always @(posedge clk) begin : compare
    #1;
    if (chk_en) begin
      chk("tx_d_vld",   64'(tx_d_vld),   64'(m_vld));
      chk("tx_p_data",  64'(tx_p_data),  64'(m_byte));
      chk("fifo_level", 64'(fifo_level), 64'(m_level));
      chk("fifo_full",  64'(fifo_full),  64'(m_full));
      chk("drop_err",   64'(drop_err),   64'(m_drop));
      chk("sched_busy", 64'(sched_busy), 64'(m_sbusy));
    end
    if (tx_d_vld === 1'b1) begin
      slog.push_back(tx_p_data);
      clog.push_back(cyc);
    end
  end

  // UART transmitter stand-in: reacts to strobes at the falling edge.
  int bcnt = 0;
  always @(negedge clk) begin : uart
    case (bmode)
      1: begin tx_busy = 1'b0; bcnt = 0; end
      2: begin tx_busy = 1'b1; bcnt = 0; end
      default: begin
        if (bcnt > 0) begin
          bcnt--;
          tx_busy = (bcnt != 0);
        end else if (tx_d_vld === 1'b1 && (bmode == 0 || $urandom_range(0, 7) != 0)) begin
          tx_busy = 1'b1;
          bcnt = (bmode == 0) ? 10 : int'($urandom_range(1, 12));
        end else begin
          tx_busy = 1'b0;
        end
      end
    endcase
  end

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((sched_busy !== 1'b0 || fifo_level != 0 || tx_busy) && n < budget);
    chk({tag, "_drained"}, 64'(sched_busy | (fifo_level != 0)), 64'(0));
  endtask

  task automatic check_log(input string nm, input bq_t exp);
    chk({nm, "_count"}, 64'(slog.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size() && k < slog.size(); k++)
      chk($sformatf("%s_byte%0d", nm, k), 64'(slog[k]), 64'(exp[k]));
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    bq_t e;
    int  n0, n, sz;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_d_vld",  64'(tx_d_vld),   64'(0));
    chk("rst_tx_p_data", 64'(tx_p_data),  64'(0));
    chk("rst_level",     64'(fifo_level), 64'(0));
    chk("rst_sched_busy",64'(sched_busy), 64'(0));
    chk("rst_drop_err",  64'(drop_err),   64'(0));
    chk_en = 1'b1;
    RST = 1'b0;
    bmode = 0;
    @(negedge clk);

    // single RF word, latency and LSB-first order
    slog.delete(); clog.delete();
    n0 = cyc + 1;
    rf_vld = 1'b1; rf_data = 32'hDEADBEEF;
    @(negedge clk); rf_vld = 1'b0;
    wait_idle(400, "t1");
    e = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef FRAME_HDR_EN
    e.push_front(8'h5A);
`endif
    check_log("t1", e);
    if (clog.size() > 0) chk("t1_first_strobe_cycle", 64'(clog[0]), 64'(n0 + 2));

    // single ALU word
    slog.delete(); clog.delete();
    @(negedge clk);
    alu_vld = 1'b1; alu_data = 64'h0123456789ABCDEF;
    @(negedge clk); alu_vld = 1'b0;
    wait_idle(600, "t2");
    e = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
`ifdef FRAME_HDR_EN
    e.push_front(8'hA5);
`endif
    check_log("t2", e);

    // RF and ALU in the same cycle: RF first
    slog.delete(); clog.delete();
    rf_vld = 1'b1; rf_data = 32'h11223344;
    alu_vld = 1'b1; alu_data = 64'h1122334455667788;
    @(negedge clk); rf_vld = 1'b0; alu_vld = 1'b0;
    chk("t3_level_after_dual", 64'(fifo_level), 64'(2));
    wait_idle(900, "t3");
    e = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef FRAME_HDR_EN
    e.insert(4, 8'hA5);
    e.push_front(8'h5A);
`endif
    check_log("t3", e);

    // overflow while the line is busy
    bmode = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      rf_vld = 1'b1; rf_data = $urandom;
      @(negedge clk);
    end
    rf_data = $urandom;
    @(negedge clk); rf_vld = 1'b0;
    chk("t4_drop_err", 64'(drop_err),   64'(1));
    chk("t4_full",     64'(fifo_full),  64'(1));
    chk("t4_level",    64'(fifo_level), 64'(4));
    @(negedge clk);
    chk("t4_drop_pulse_end", 64'(drop_err), 64'(0));
    bmode = 0;
    wait_idle(2000, "t4");

    // no busy response: byte re-strobed after the timeout, then reset mid-word
    slog.delete(); clog.delete();
    bmode = 1;
    @(negedge clk);
    rf_vld = 1'b1; rf_data = 32'h11223344;
    @(negedge clk); rf_vld = 1'b0;
    n = 0;
    while (slog.size() < 2 && n < 100) begin @(negedge clk); n++; end
    chk("t5_restrobe_seen", 64'(slog.size() >= 2), 64'(1));
    if (slog.size() >= 2) begin
`ifdef FRAME_HDR_EN
      chk("t5_byte0", 64'(slog[0]), 64'(8'h5A));
      chk("t5_byte1", 64'(slog[1]), 64'(8'h5A));
`else
      chk("t5_byte0", 64'(slog[0]), 64'(8'h44));
      chk("t5_byte1", 64'(slog[1]), 64'(8'h44));
`endif
      chk("t5_gap", 64'(clog[1] - clog[0]), 64'(TMO + 1));
    end
    rf_vld = 1'b1; rf_data = 32'hA5A5F00D;
    @(negedge clk); rf_vld = 1'b0;
    chk("t5_level_before_rst", 64'(fifo_level), 64'(1));
    RST = 1'b1;
    @(negedge clk); RST = 1'b0;
    chk("t5_rst_vld",   64'(tx_d_vld),   64'(0));
    chk("t5_rst_data",  64'(tx_p_data),  64'(0));
    chk("t5_rst_level", 64'(fifo_level), 64'(0));
    chk("t5_rst_busy",  64'(sched_busy), 64'(0));
    sz = slog.size();
    repeat (40) @(negedge clk);
    chk("t5_no_strobe_after_rst", 64'(slog.size()), 64'(sz));
    bmode = 0;

    // randomized traffic with a random line model and rare resets
    bmode = 3;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rf_vld   = ($urandom_range(0, (i < 1500) ? 5 : 15) == 0);
      alu_vld  = ($urandom_range(0, (i < 1500) ? 7 : 19) == 0);
      rf_data  = $urandom;
      alu_data = {$urandom, $urandom};
      RST      = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rf_vld = 1'b0; alu_vld = 1'b0; RST = 1'b0;
    bmode = 0;
    wait_idle(3000, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
